// File: rtl/four_bank_mem_if.sv
// four_bank_mem_if: request/response bundle between the cache controller
// (master) and the four-bank main memory (slave).
//   addr, data_in, wr, rd      : request from the controller
//   data_out, data_valid       : in-order read return
//   stall, err, busy           : acceptance status and per-bank busy flags
interface four_bank_mem_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              stall;
  logic [3:0]        busy;
  logic              err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, data_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, data_valid, stall, busy, err
  );
endinterface

// File: rtl/four_bank_mem.sv
// four_bank_mem: word-interleaved four-bank memory. addr[1:0] selects the bank,
// the next BANK_DEPTH_W bits select the row. Each bank is busy for
// BANK_LATENCY-1 cycles after it accepts; reads return in order after exactly
// BANK_LATENCY cycles.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : four_bank_mem_if slave port (request, read return, stall/err/busy)
module four_bank_mem #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned BANK_LATENCY = 4,
  parameter int unsigned BANK_DEPTH_W = ADDR_W - 2
) (
  input logic             clk,
  input logic             rst,
  four_bank_mem_if.slave  bus
);

  // Per-bank return pipeline depth; the shared output register is the final stage.
  localparam int unsigned Pipe = BANK_LATENCY - 1;

  logic [1:0]              bank;
  logic [BANK_DEPTH_W-1:0] row;
  logic                    req_one;
  logic                    accept;
  logic [DATA_W-1:0]       rd_word;

  logic [DATA_W-1:0] mem_q [4][2**BANK_DEPTH_W];

  logic [3:0][3:0]                    cnt_q, cnt_d;
  logic [3:0]                         busy_q, busy_d;
  logic [3:0][Pipe-1:0]               pv_q, pv_d;
  logic [3:0][Pipe-1:0][DATA_W-1:0]   pd_q, pd_d;
  logic [DATA_W-1:0]                  data_out_q, data_out_d;
  logic                               data_valid_q, data_valid_d;

  assign bank    = bus.addr[1:0];
  assign row     = bus.addr[BANK_DEPTH_W+1:2];
  assign req_one = bus.rd ^ bus.wr;
  assign accept  = req_one & ~busy_q[bank];
  assign rd_word = mem_q[bank][row];

  assign bus.stall      = req_one & busy_q[bank];
  assign bus.err        = bus.rd & bus.wr;
  assign bus.busy       = busy_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

  always_comb begin
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    pv_d         = pv_q;
    pd_d         = pd_q;
    data_valid_d = 1'b0;
    data_out_d   = data_out_q;
    for (int b = 0; b < 4; b++) begin
      if (accept && (bank == 2'(b))) begin
        cnt_d[b] = 4'(BANK_LATENCY - 1);
      end else if (cnt_q[b] != 4'd0) begin
        cnt_d[b] = cnt_q[b] - 4'd1;
      end
      busy_d[b] = (cnt_d[b] != 4'd0);

      // Words are zeroed when not valid so the four bank outputs can simply be OR-ed.
      pv_d[b][0] = accept && bus.rd && (bank == 2'(b));
      pd_d[b][0] = pv_d[b][0] ? rd_word : '0;
      for (int s = 1; s < int'(Pipe); s++) begin
        pv_d[b][s] = pv_q[b][s-1];
        pd_d[b][s] = pd_q[b][s-1];
      end
    end
    data_valid_d = |{pv_q[3][Pipe-1], pv_q[2][Pipe-1], pv_q[1][Pipe-1], pv_q[0][Pipe-1]};
    if (data_valid_d) begin
      data_out_d = pd_q[0][Pipe-1] | pd_q[1][Pipe-1] | pd_q[2][Pipe-1] | pd_q[3][Pipe-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      busy_q       <= '0;
      pv_q         <= '0;
      pd_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      pv_q         <= pv_d;
      pd_q         <= pd_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      mem_q[bank][row] <= bus.data_in;
    end
  end

endmodule

// File: tb/tb_four_bank_mem.sv
// tb_four_bank_mem: directed self-checking bench for four_bank_mem
// (BANK_LATENCY = 4). Inputs change 1 ns after the rising edge; outputs are
// checked a few ns later, well away from the edge.
module tb_four_bank_mem;

  localparam int unsigned Lat = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  four_bank_mem_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  four_bank_mem #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .BANK_LATENCY(Lat),
    .BANK_DEPTH_W(14)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Hold the request until accepted (bounded), then go idle.
  task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    int n;
    drive(r, w, a, d);
    n = 0;
    #1;
    while (bus.stall && n < 20) begin
      step();
      n++;
      #1;
    end
    if (n >= 20) check_eq("issue_timeout", 32'(n), 32'd0);
    step();
    idle();
  endtask

  task automatic wait_free();
    int n;
    n = 0;
    while (bus.busy != 4'b0000 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check_eq("wait_free_timeout", 32'(n), 32'd0);
  endtask

  // Read with the full latency and data checked.
  task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    int k;
    issue(1'b1, 1'b0, a, 16'h0);
    k = 1;
    #1;
    while (!bus.data_valid && k < 20) begin
      step();
      k++;
      #1;
    end
    check_eq({tag, "_lat"}, 32'(k), 32'(Lat));
    check_eq({tag, "_data"}, 32'(bus.data_out), 32'(exp));
    step();
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle();
    repeat (3) step();

    // Reset state
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_dv", 32'(bus.data_valid), 32'h0);
    check_eq("rst_dout", 32'(bus.data_out), 32'h0);
    check_eq("rst_stall", 32'(bus.stall), 32'h0);
    check_eq("rst_err", 32'(bus.err), 32'h0);
    #3 rst = 1'b1;
    step();

    // Single write/read with same-bank stall
    drive(1'b0, 1'b1, 16'h0005, 16'hBEEF);
    #1 check_eq("wr_stall_c0", 32'(bus.stall), 32'h0);
    step();
    drive(1'b1, 1'b0, 16'h0005, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      check_eq("wr_busy", 32'(bus.busy), 32'b0010);
      check_eq("rd_stall", 32'(bus.stall), 32'h1);
      step();
    end
    #1 check_eq("rd_accept_c4", 32'(bus.stall), 32'h0);
    step();
    idle();
    for (int c = 5; c <= 7; c++) begin
      #1 check_eq("rd_early_dv", 32'(bus.data_valid), 32'h0);
      step();
    end
    #1;
    check_eq("rd_dv_c8", 32'(bus.data_valid), 32'h1);
    check_eq("rd_dout_c8", 32'(bus.data_out), 32'hBEEF);
    step();
    #1;
    check_eq("dv_pulse_c9", 32'(bus.data_valid), 32'h0);
    check_eq("dout_hold_c9", 32'(bus.data_out), 32'hBEEF);

    // Preload
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 16'(16'h0010 + i), 16'(i + 1));
    issue(1'b0, 1'b1, 16'h0000, 16'h1111);
    issue(1'b0, 1'b1, 16'h0004, 16'h2222);
    issue(1'b0, 1'b1, 16'h0002, 16'h3333);
    wait_free();
    repeat (Lat) step();

    // Line fill: four banks back to back, no stall
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0);
      #1 check_eq("fill_stall", 32'(bus.stall), 32'h0);
      step();
    end
    idle();
    #1 check_eq("fill_busy_c4", 32'(bus.busy), 32'b1110);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("fill_dv", 32'(bus.data_valid), 32'h1);
      check_eq("fill_dout", 32'(bus.data_out), 32'(i + 1));
      step();
    end
    #1 check_eq("fill_dv_c8", 32'(bus.data_valid), 32'h0);
    wait_free();

    // Same-bank conflict
    drive(1'b1, 1'b0, 16'h0000, 16'h0);
    #1 check_eq("conf_stall_c0", 32'(bus.stall), 32'h0);
    step();
    drive(1'b1, 1'b0, 16'h0004, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      #1 check_eq("conf_stall", 32'(bus.stall), 32'h1);
      step();
    end
    #1;
    check_eq("conf_stall_c4", 32'(bus.stall), 32'h0);
    check_eq("conf_dv_c4", 32'(bus.data_valid), 32'h1);
    check_eq("conf_dout_c4", 32'(bus.data_out), 32'h1111);
    step();
    idle();
    for (int c = 5; c <= 7; c++) begin
      #1 check_eq("conf_gap_dv", 32'(bus.data_valid), 32'h0);
      step();
    end
    #1;
    check_eq("conf_dv_c8", 32'(bus.data_valid), 32'h1);
    check_eq("conf_dout_c8", 32'(bus.data_out), 32'h2222);
    step();
    wait_free();

    // Error: rd and wr together
    drive(1'b1, 1'b1, 16'h0002, 16'hDEAD);
    #1;
    check_eq("err_flag", 32'(bus.err), 32'h1);
    check_eq("err_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    #1;
    check_eq("err_busy", 32'(bus.busy), 32'h0);
    check_eq("err_clear", 32'(bus.err), 32'h0);
    check_eq("err_no_dv", 32'(bus.data_valid), 32'h0);
    read_check("err_old", 16'h0002, 16'h3333);

    // Top address, bank 3
    drive(1'b0, 1'b1, 16'hFFFF, 16'hA5A5);
    step();
    idle();
    #1 check_eq("top_busy", 32'(bus.busy), 32'b1000);
    wait_free();
    read_check("top_rd", 16'hFFFF, 16'hA5A5);
    read_check("top_bank0", 16'h0000, 16'h1111);

    // Reset with reads in flight
    wait_free();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0);
      step();
    end
    idle();
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(bus.busy), 32'h0);
    check_eq("mid_rst_dv", 32'(bus.data_valid), 32'h0);
    check_eq("mid_rst_dout", 32'(bus.data_out), 32'h0);
    step();
    #2 rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      #1 if (bus.data_valid) seen++;
    end
    check_eq("post_rst_dv", 32'(seen), 32'h0);
    read_check("post_rst_keep", 16'h0005, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
